ifid_stage: RTL and testbench
=============================

# ifid_stage

Fetch stage of the RV32I pipeline: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register. It sits directly upstream of the load-use hazard unit, feeding it `ifid_rs1`/`ifid_rs2` and obeying its `PCWrite`/`ifidWrite` hold requests. It also accepts taken-branch/jump redirects from EX, flushes the wrong-path instruction, and counts stalled cycles for performance debug.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`)
- `CNT_W`, 16, width of the stall counter

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `PCWrite`  in  1  from hazard unit; 1 = PC may advance, 0 = hold PC
- `ifidWrite`  in  1  from hazard unit; 1 = IF/ID may load, 0 = hold IF/ID
- `branch_taken`  in  1  from EX; redirect request, one-cycle pulse
- `branch_target`  in  32  redirect address, valid with `branch_taken`
- `imem_addr`  out  32  instruction-memory address, equal to `pc`
- `imem_rdata`  in  32  instruction word, combinationally valid same cycle as `imem_addr`
- `pc`  out  32  current fetch PC
- `ifid_pc`  out  32  PC of the instruction held in IF/ID
- `ifid_instr`  out  32  instruction held in IF/ID
- `ifid_valid`  out  1  IF/ID holds a real (non-bubble) instruction
- `ifid_rs1`  out  5  `ifid_instr[19:15]` when valid, else 0
- `ifid_rs2`  out  5  `ifid_instr[24:20]` when valid, else 0
- `stall_cnt`  out  CNT_W  number of cycles with `PCWrite`=0, saturating

## Operation
- PC next-value priority, highest first:
  1. `branch_taken`=1 → `pc <= {branch_target[31:2],2'b00}` (low bits forced to 0)
  2. `PCWrite`=0 → `pc` holds
  3. otherwise → `pc <= pc + 4`, 32-bit wrap (32'hFFFF_FFFC + 4 = 0)
- IF/ID next-value priority, highest first:
  1. `branch_taken`=1 → flush: `ifid_instr <= NOP_INSTR`, `ifid_valid <= 0`, `ifid_pc <= 0`
  2. `ifidWrite`=0 → hold all IF/ID fields
  3. otherwise → `ifid_instr <= imem_rdata`, `ifid_pc <= pc`, `ifid_valid <= 1`
- Redirect overrides hold: `branch_taken` with `PCWrite`=0 or `ifidWrite`=0 still redirects and flushes.
- `ifid_rs1`/`ifid_rs2` are combinational from the register; forced to 0 when `ifid_valid`=0 so bubbles never create false hazards (x0 is ignored downstream).
- `stall_cnt` increments each cycle `PCWrite`=0 and `branch_taken`=0; saturates at all-ones; never wraps.
- `PCWrite` and `ifidWrite` are expected equal; when they differ, each controls only its own register as stated.

## Timing
- Reset (async, `rst_n`=0): `pc`=RESET_PC, `ifid_instr`=NOP_INSTR, `ifid_pc`=0, `ifid_valid`=0, `stall_cnt`=0; outputs valid immediately, not at the next edge.
- Reset release: first fetch at RESET_PC. First valid IF/ID contents one edge after release.
- Fetch latency: instruction addressed in cycle N appears on `ifid_instr` in cycle N+1.
- Redirect: `branch_taken` in cycle N → `pc`=target in N+1; IF/ID bubble in N+1; target instruction in IF/ID in N+2. Penalty: 1 flushed slot here; the ID→EX slot is the consumer's flush.
- Hold: `PCWrite`=`ifidWrite`=0 for K cycles → `pc` and IF/ID frozen exactly K cycles, resume on the next edge after release.
- Reset mid-stall or mid-redirect: reset wins unconditionally; no pending redirect survives.

## Structure
- Shared pipeline package: `NOP_INSTR`, `RESET_PC` default, RV32I field position constants (rs1 19:15, rs2 24:20).
- One sub-module natural: `pc_reg` (PC register plus next-PC mux); IF/ID register and counter stay in `ifid_stage`.

## Test plan
- Reset then free-run 4 cycles, `imem_rdata`=`pc`^32'hA5A5_0000 → `pc` 0,4,8,12; `ifid_pc` lags by one; `ifid_valid`=1 from cycle 2.
- Load-use hold: `PCWrite`=`ifidWrite`=0 for 2 cycles at `pc`=8 → `pc`=8 and IF/ID frozen 2 cycles; `stall_cnt`=2; then `pc`=12.
- Redirect: `branch_taken`=1, `branch_target`=32'h100 at `pc`=16 → next cycle `pc`=32'h100, `ifid_valid`=0, `ifid_rs1`=`ifid_rs2`=0; following cycle `ifid_pc`=32'h100.
- Redirect during hold: `branch_taken`=1 with `PCWrite`=0, target 32'h203 → `pc`=32'h200, IF/ID flushed, `stall_cnt` unchanged.
- Wrap/saturate: preload `pc`=32'hFFFF_FFFC via redirect, run → `pc`=0; with CNT_W=4 hold 20 cycles → `stall_cnt`=15.
- Async reset asserted mid-hold between edges → all outputs at reset values before next edge.

Source files
------------

// File: rtl/ifid_pkg.sv
// Shared RV32I front-end definitions: bubble encoding, reset PC default,
// instruction field positions and the IF/ID register layout.
package ifid_pkg;

   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
   localparam logic [31:0] PC_STEP_C   = 32'h0000_0004;

   localparam int REG_IDX_W = 5;
   localparam int RS1_LSB   = 15;
   localparam int RS2_LSB   = 20;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } ifid_t;

   // Register-index field starting at bit position lsb.
   function automatic logic [REG_IDX_W-1:0] rs_field(input logic [31:0] instr,
                                                    input int          lsb);
      return instr[lsb +: REG_IDX_W];
   endfunction

   // Instruction fetch is word aligned: the two low address bits are dropped.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifid_stage_pc_reg.sv
// Program counter register with its next-PC selection
// (redirect, then hold, then sequential +4 with 32-bit wrap).
module pc_reg
   import ifid_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_C
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_write,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc
);

   logic [31:0] pc_r;
   logic [31:0] pc_next_s;

   // Next-PC selection: a redirect beats a hold request, otherwise step by one word.
   always_comb begin
      pc_next_s = pc_r;
      if (branch_taken) begin
         pc_next_s = align_word(branch_target);
      end else if (pc_write) begin
         pc_next_s = pc_r + PC_STEP_C;
      end else begin
         pc_next_s = pc_r;
      end
   end

   // PC state register; reset takes effect immediately, independent of the clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r <= RESET_PC;
      end else begin
         pc_r <= pc_next_s;
      end
   end

   assign pc = pc_r;

endmodule

// File: rtl/ifid_stage.sv
// Fetch stage: owns the PC (via pc_reg), drives the instruction-memory
// address, holds the IF/ID pipeline register and counts stalled cycles.
module ifid_stage
   import ifid_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_C,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C,
   parameter int          CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 PCWrite,
   input  logic                 ifidWrite,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_target,
   output logic [31:0]          imem_addr,
   input  logic [31:0]          imem_rdata,
   output logic [31:0]          pc,
   output logic [31:0]          ifid_pc,
   output logic [31:0]          ifid_instr,
   output logic                 ifid_valid,
   output logic [REG_IDX_W-1:0] ifid_rs1,
   output logic [REG_IDX_W-1:0] ifid_rs2,
   output logic [CNT_W-1:0]     stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

   localparam ifid_t IFID_BUBBLE_C = '{instr: NOP_INSTR, pc: 32'h0000_0000, valid: 1'b0};

   logic [31:0]      pc_s;
   ifid_t            ifid_r;
   ifid_t            ifid_next_s;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] stall_cnt_next_s;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .pc_write      (PCWrite),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc            (pc_s)
   );

   // IF/ID next value: a redirect flushes the wrong-path slot even during a hold.
   always_comb begin
      ifid_next_s = ifid_r;
      if (branch_taken) begin
         ifid_next_s = IFID_BUBBLE_C;
      end else if (ifidWrite) begin
         ifid_next_s.instr = imem_rdata;
         ifid_next_s.pc    = pc_s;
         ifid_next_s.valid = 1'b1;
      end else begin
         ifid_next_s = ifid_r;
      end
   end

   // Stall counter next value: counts plain holds only, sticks at all-ones.
   always_comb begin
      stall_cnt_next_s = stall_cnt_r;
      if (!PCWrite && !branch_taken && (stall_cnt_r != CNT_MAX_C)) begin
         stall_cnt_next_s = stall_cnt_r + CNT_ONE_C;
      end else begin
         stall_cnt_next_s = stall_cnt_r;
      end
   end

   // IF/ID pipeline register; resets to a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_r <= IFID_BUBBLE_C;
      end else begin
         ifid_r <= ifid_next_s;
      end
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_r <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_r <= stall_cnt_next_s;
      end
   end

   assign pc         = pc_s;
   assign imem_addr  = pc_s;
   assign ifid_pc    = ifid_r.pc;
   assign ifid_instr = ifid_r.instr;
   assign ifid_valid = ifid_r.valid;
   assign stall_cnt  = stall_cnt_r;

   // Bubbles report x0 so the hazard unit never sees a false dependency.
   assign ifid_rs1 = ifid_r.valid ? rs_field(ifid_r.instr, RS1_LSB) : {REG_IDX_W{1'b0}};
   assign ifid_rs2 = ifid_r.valid ? rs_field(ifid_r.instr, RS2_LSB) : {REG_IDX_W{1'b0}};

endmodule

// File: tb/tb_ifid_stage.sv
// Self-checking bench for ifid_stage: directed scenarios with literal
// expectations, then randomized control traffic against a behavioural model.
module tb_ifid_stage;

   localparam int CNT_W = 4;

   logic        clk;
   logic        rst_n;
   logic        PCWrite;
   logic        ifidWrite;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        ifid_valid;
   logic [4:0]  ifid_rs1;
   logic [4:0]  ifid_rs2;
   logic [CNT_W-1:0] stall_cnt;

   int n_vec;
   int n_err;
   logic chk_en;

   // instruction memory content: word = (addr * mul) ^ key
   logic [31:0] mem_mul;
   logic [31:0] mem_key;

   ifid_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013),
      .CNT_W     (CNT_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PCWrite       (PCWrite),
      .ifidWrite     (ifidWrite),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .pc            (pc),
      .ifid_pc       (ifid_pc),
      .ifid_instr    (ifid_instr),
      .ifid_valid    (ifid_valid),
      .ifid_rs1      (ifid_rs1),
      .ifid_rs2      (ifid_rs2),
      .stall_cnt     (stall_cnt)
   );

   assign imem_rdata = (imem_addr * mem_mul) ^ mem_key;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;
   logic        m_valid;
   int          m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc    <= 32'h0;
         m_instr <= 32'h0000_0013;
         m_ipc   <= 32'h0;
         m_valid <= 1'b0;
         m_cnt   <= 0;
      end else begin
         if (branch_taken) begin
            m_pc    <= branch_target & 32'hFFFF_FFFC;
            m_instr <= 32'h0000_0013;
            m_ipc   <= 32'h0;
            m_valid <= 1'b0;
         end else begin
            if (PCWrite) m_pc <= m_pc + 32'd4;
            if (ifidWrite) begin
               m_instr <= (m_pc * mem_mul) ^ mem_key;
               m_ipc   <= m_pc;
               m_valid <= 1'b1;
            end
            if (!PCWrite) m_cnt <= (m_cnt >= 15) ? 15 : m_cnt + 1;
         end
      end
   end

   // compare DUT against model on every falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("pc",         pc,         m_pc);
         chk("imem_addr",  imem_addr,  m_pc);
         chk("ifid_pc",    ifid_pc,    m_ipc);
         chk("ifid_instr", ifid_instr, m_instr);
         chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
         chk("ifid_rs1",   {27'd0, ifid_rs1}, m_valid ? {27'd0, m_instr[19:15]} : 32'd0);
         chk("ifid_rs2",   {27'd0, ifid_rs2}, m_valid ? {27'd0, m_instr[24:20]} : 32'd0);
         chk("stall_cnt",  {28'd0, stall_cnt}, m_cnt);
      end
   end

   // advance to just after the next falling edge
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      chk_en = 1'b0;
      mem_mul = 32'd1;
      mem_key = 32'hA5A5_0000;
      PCWrite = 1'b1;
      ifidWrite = 1'b1;
      branch_taken = 1'b0;
      branch_target = 32'h0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) cyc();

      // reset state
      chk("rst pc",        pc,         32'h0);
      chk("rst ifid_instr", ifid_instr, 32'h0000_0013);
      chk("rst ifid_valid", {31'd0, ifid_valid}, 32'd0);
      chk("rst stall_cnt", {28'd0, stall_cnt}, 32'd0);

      rst_n = 1'b1;
      chk_en = 1'b1;

      // free run
      cyc();
      chk("run1 pc",        pc,         32'h4);
      chk("run1 ifid_pc",   ifid_pc,    32'h0);
      chk("run1 ifid_instr", ifid_instr, 32'hA5A5_0000);
      chk("run1 ifid_valid", {31'd0, ifid_valid}, 32'd1);
      cyc();
      chk("run2 pc",        pc,         32'h8);
      chk("run2 ifid_pc",   ifid_pc,    32'h4);

      // load-use hold for 2 cycles at pc=8
      PCWrite = 1'b0; ifidWrite = 1'b0;
      cyc();
      chk("hold1 pc", pc, 32'h8);
      cyc();
      chk("hold2 pc",        pc,         32'h8);
      chk("hold2 ifid_pc",   ifid_pc,    32'h4);
      chk("hold2 stall_cnt", {28'd0, stall_cnt}, 32'd2);
      PCWrite = 1'b1; ifidWrite = 1'b1;
      cyc();
      chk("resume pc",      pc,      32'hC);
      chk("resume ifid_pc", ifid_pc, 32'h8);
      cyc();
      chk("pc16", pc, 32'h10);

      // redirect
      branch_taken = 1'b1; branch_target = 32'h100;
      cyc();
      branch_taken = 1'b0;
      chk("br pc",        pc,       32'h100);
      chk("br valid",     {31'd0, ifid_valid}, 32'd0);
      chk("br rs1",       {27'd0, ifid_rs1}, 32'd0);
      chk("br rs2",       {27'd0, ifid_rs2}, 32'd0);
      cyc();
      chk("br+2 ifid_pc", ifid_pc, 32'h100);
      chk("br+2 ifid_instr", ifid_instr, 32'hA5A5_0100);

      // redirect during hold, misaligned target
      PCWrite = 1'b0; ifidWrite = 1'b0;
      branch_taken = 1'b1; branch_target = 32'h203;
      cyc();
      branch_taken = 1'b0; PCWrite = 1'b1; ifidWrite = 1'b1;
      chk("brh pc",        pc, 32'h200);
      chk("brh valid",     {31'd0, ifid_valid}, 32'd0);
      chk("brh stall_cnt", {28'd0, stall_cnt}, 32'd2);

      // wrap
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      cyc();
      branch_taken = 1'b0;
      chk("wrap pre", pc, 32'hFFFF_FFFC);
      cyc();
      chk("wrap pc", pc, 32'h0);
      chk("wrap ifid_pc", ifid_pc, 32'hFFFF_FFFC);

      // saturation
      PCWrite = 1'b0; ifidWrite = 1'b0;
      repeat (20) cyc();
      chk("sat stall_cnt", {28'd0, stall_cnt}, 32'd15);
      chk("sat pc", pc, 32'h0);

      // async reset between edges, mid-hold
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst pc",         pc,         32'h0);
      chk("arst ifid_instr", ifid_instr, 32'h0000_0013);
      chk("arst ifid_pc",    ifid_pc,    32'h0);
      chk("arst ifid_valid", {31'd0, ifid_valid}, 32'd0);
      chk("arst stall_cnt",  {28'd0, stall_cnt}, 32'd0);
      chk("arst rs1",        {27'd0, ifid_rs1}, 32'd0);
      cyc();
      rst_n = 1'b1;
      PCWrite = 1'b1; ifidWrite = 1'b1;

      // randomized traffic
      mem_mul = $urandom() | 32'd1;
      mem_key = $urandom();
      for (int i = 0; i < 2000; i++) begin
         cyc();
         rst_n = ($urandom_range(0, 199) != 0);
         PCWrite = ($urandom_range(0, 3) != 0);
         ifidWrite = ($urandom_range(0, 9) == 0) ? ~PCWrite : PCWrite;
         branch_taken = ($urandom_range(0, 7) == 0);
         branch_target = $urandom();
      end
      cyc();
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
